// File: rtl/nibble_mc_core_if.sv
// -----------------------------------------------------------------------------
// nibble_mc_core_if
// Memory-side bus of the nibble multi-cycle core: program ROM fetch port and
// data RAM access port, both synchronous with one cycle of read latency.
//
// Signals
//   rom_addr   core->rom  PC_W    fetch address (= pc)
//   rom_rd     core->rom  1       fetch strobe
//   rom_data   rom->core  INST_W  instruction word, valid the cycle after rom_rd
//   ram_addr   core->ram  ADDR_W  data address (= ir.addr)
//   ram_we     core->ram  1       single-cycle write strobe
//   ram_wdata  core->ram  DATA_W  write data (ALU result)
//   ram_rdata  ram->core  DATA_W  read data, valid the cycle after the address
//
// Modports
//   master  core side
//   slave   memory side
// -----------------------------------------------------------------------------
interface nibble_mc_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_W   = 4,
    parameter int unsigned OP_W   = 3
);
    localparam int unsigned INST_W = OP_W + 1 + 2 * DATA_W + ADDR_W;

    logic [PC_W-1:0]   rom_addr;
    logic              rom_rd;
    logic [INST_W-1:0] rom_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output rom_addr,
        output rom_rd,
        input  rom_data,
        output ram_addr,
        output ram_we,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  rom_addr,
        input  rom_rd,
        output rom_data,
        input  ram_addr,
        input  ram_we,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/nibble_mc_core.sv
// -----------------------------------------------------------------------------
// nibble_mc_core
// Multi-cycle nibble processor core: PC, instruction register, decoder, ALU
// and flags under one FSM (FETCH -> DECODE -> EXEC [-> MEM] -> FETCH), with
// HALT parking the core until reset and a global stall input.
//
// Ports
//   clock_i       clock, rising edge
//   reset_i       synchronous, active-high; wins over ena_i and in-flight ops
//   ena_i         1 = advance, 0 = stall (every register holds)
//   bus           ROM/RAM memory bus (master side)
//   pc_o, acc_o   architectural registers
//   zero_o        zero flag
//   carry_o       carry / borrow flag
//   halted_o      sticky after HALT
//   instr_done_o  one-cycle pulse when an instruction retires
//   op_o, x_o, y_o, addr_o  decoded instruction-register fields
// -----------------------------------------------------------------------------
module nibble_mc_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_W   = 4,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              ena_i,
    nibble_mc_core_if.master  bus,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] acc_o,
    output logic              zero_o,
    output logic              carry_o,
    output logic              halted_o,
    output logic              instr_done_o,
    output logic [OP_W-1:0]   op_o,
    output logic [DATA_W-1:0] x_o,
    output logic [DATA_W-1:0] y_o,
    output logic [ADDR_W-1:0] addr_o
);
    localparam int unsigned INST_W = OP_W + 1 + 2 * DATA_W + ADDR_W;

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(1);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(2);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(3);
    localparam logic [OP_W-1:0] OpLd   = OP_W'(4);
    localparam logic [OP_W-1:0] OpJmp  = OP_W'(5);
    localparam logic [OP_W-1:0] OpJz   = OP_W'(6);
    localparam logic [OP_W-1:0] OpHalt = OP_W'(7);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StHalted
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              halted_q, halted_d;

    // Decoded fields; the reserved bit below op is carried in ir but ignored.
    logic [OP_W-1:0]   ir_op;
    logic [DATA_W-1:0] ir_x;
    logic [DATA_W-1:0] ir_y;
    logic [ADDR_W-1:0] ir_addr;
    logic              unused_rsv;

    assign ir_op      = ir_q[INST_W-1 -: OP_W];
    assign unused_rsv = ir_q[INST_W-OP_W-1];
    assign ir_x       = ir_q[2*DATA_W+ADDR_W-1 -: DATA_W];
    assign ir_y       = ir_q[DATA_W+ADDR_W-1 -: DATA_W];
    assign ir_addr    = ir_q[ADDR_W-1:0];

    // ALU: one extra bit catches carry-out for ADD and borrow (x<y) for SUB.
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    assign sum_ext  = {1'b0, ir_x} + {1'b0, ir_y};
    assign diff_ext = {1'b0, ir_x} - {1'b0, ir_y};

    always_comb begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
        case (ir_op)
            OpSub: begin
                alu_res   = diff_ext[DATA_W-1:0];
                alu_carry = diff_ext[DATA_W];
            end
            OpAnd: begin
                alu_res   = ir_x & ir_y;
                alu_carry = 1'b0;
            end
            default: ;
        endcase
    end

    logic [PC_W-1:0] pc_inc;
    assign pc_inc = pc_q + PC_W'(1);

    // FSM: state register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (ena_i) begin
            case (state_q)
                StFetch:  state_d = StDecode;
                StDecode: state_d = StExec;
                StExec: begin
                    if (ir_op == OpLd) begin
                        state_d = StMem;
                    end else if (ir_op == OpHalt) begin
                        state_d = StHalted;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StMem:    state_d = StFetch;
                default:  state_d = StHalted;
            endcase
        end
    end

    // FSM: outputs; every strobe is gated by reset and the stall input.
    logic rom_rd;
    logic ram_we;
    logic instr_done;

    always_comb begin
        rom_rd     = 1'b0;
        ram_we     = 1'b0;
        instr_done = 1'b0;
        if (!reset_i && ena_i) begin
            case (state_q)
                StFetch: rom_rd = 1'b1;
                StExec: begin
                    ram_we     = (ir_op == OpAdd) || (ir_op == OpSub) || (ir_op == OpAnd);
                    // LD retires one cycle later, in MEM.
                    instr_done = (ir_op != OpLd);
                end
                StMem:   instr_done = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath next state
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        halted_d = halted_q;
        if (ena_i) begin
            case (state_q)
                StDecode: ir_d = bus.rom_data;
                StExec: begin
                    pc_d = pc_inc;
                    case (ir_op)
                        OpAdd, OpSub, OpAnd: begin
                            zero_d  = (alu_res == '0);
                            carry_d = alu_carry;
                        end
                        OpJmp:  pc_d = ir_x[PC_W-1:0];
                        OpJz:   pc_d = zero_q ? ir_x[PC_W-1:0] : pc_inc;
                        OpHalt: begin
                            pc_d     = pc_q;
                            halted_d = 1'b1;
                        end
                        default: ;  // NOP, LD and any wider unused opcode
                    endcase
                end
                StMem: begin
                    acc_d  = bus.ram_rdata;
                    zero_d = (bus.ram_rdata == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q     <= '0;
            ir_q     <= '0;
            acc_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

    assign bus.rom_addr  = pc_q;
    assign bus.rom_rd    = rom_rd;
    assign bus.ram_addr  = ir_addr;
    assign bus.ram_we    = ram_we;
    assign bus.ram_wdata = alu_res;

    assign pc_o         = pc_q;
    assign acc_o        = acc_q;
    assign zero_o       = zero_q;
    assign carry_o      = carry_q;
    assign halted_o     = halted_q;
    assign instr_done_o = instr_done;
    assign op_o         = ir_op;
    assign x_o          = ir_x;
    assign y_o          = ir_y;
    assign addr_o       = ir_addr;
endmodule

// File: tb/tb_nibble_mc_core.sv
// -----------------------------------------------------------------------------
// tb_nibble_mc_core
// Directed bench for nibble_mc_core with behavioural sync ROM/RAM models.
// Expected retire states and RAM writes are queued when the program is loaded;
// independent monitors pop and compare them as the core retires / writes.
// -----------------------------------------------------------------------------
module tb_nibble_mc_core;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned PC_W   = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned INST_W = OP_W + 1 + 2 * DATA_W + ADDR_W;

    localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND = 3'd3;
    localparam logic [2:0] LD = 3'd4, JMP = 3'd5, JZ = 3'd6, HALT = 3'd7;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ena   = 1'b1;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc;
    logic              zero, carry, halted, instr_done;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] x, y;
    logic [ADDR_W-1:0] addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    nibble_mc_core_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .OP_W(OP_W)
    ) bus ();

    nibble_mc_core #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .OP_W(OP_W)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .ena_i        (ena),
        .bus          (bus.master),
        .pc_o         (pc),
        .acc_o        (acc),
        .zero_o       (zero),
        .carry_o      (carry),
        .halted_o     (halted),
        .instr_done_o (instr_done),
        .op_o         (op),
        .x_o          (x),
        .y_o          (y),
        .addr_o       (addr)
    );

    // Memory models
    logic [INST_W-1:0] rom [16];
    logic [DATA_W-1:0] ram [16];

    always @(posedge clock) begin
        if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
            ram[2] <= 8'hA5;
        end else if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    function automatic logic [INST_W-1:0] enc(input logic [2:0] o, input logic [7:0] a,
                                              input logic [7:0] b, input logic [3:0] ad);
        return {o, 1'b0, a, b, ad};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] acc;
        logic              z;
        logic              c;
        logic              h;
    } ret_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    ret_t ret_q[$];
    wr_t  wr_q[$];
    ret_t ret_e;
    wr_t  wr_e;

    function automatic ret_t mk_ret(input logic [3:0] p, input logic [7:0] a,
                                    input logic z, input logic c, input logic h);
        ret_t r;
        r.pc = p; r.acc = a; r.z = z; r.c = c; r.h = h;
        return r;
    endfunction

    function automatic wr_t mk_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a; w.d = d;
        return w;
    endfunction

    // Retire monitor: compare architectural state just after the retiring edge.
    always @(posedge clock) begin
        if (instr_done) begin
            #1;
            if (ret_q.size() == 0) begin
                check("retire_unexpected", 32'(instr_done), 32'(0));
            end else begin
                ret_e = ret_q.pop_front();
                check("retire_pc", 32'(pc), 32'(ret_e.pc));
                check("retire_acc", 32'(acc), 32'(ret_e.acc));
                check("retire_zero", 32'(zero), 32'(ret_e.z));
                check("retire_carry", 32'(carry), 32'(ret_e.c));
                check("retire_halted", 32'(halted), 32'(ret_e.h));
            end
        end
    end

    // Write monitor
    always @(negedge clock) begin
        if (bus.ram_we) begin
            if (wr_q.size() == 0) begin
                check("write_unexpected", 32'(bus.ram_we), 32'(0));
            end else begin
                wr_e = wr_q.pop_front();
                check("write_addr", 32'(bus.ram_addr), 32'(wr_e.a));
                check("write_data", 32'(bus.ram_wdata), 32'(wr_e.d));
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int cyc;
        for (int i = 0; i < 16; i++) rom[i] = enc(NOP, 8'h00, 8'h00, 4'h0);
        rom[0] = enc(ADD, 8'hF0, 8'h20, 4'h3);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", 32'(pc), 32'(0));
        check("rst_acc", 32'(acc), 32'(0));
        check("rst_zero", 32'(zero), 32'(0));
        check("rst_carry", 32'(carry), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_rom_rd", 32'(bus.rom_rd), 32'(0));
        check("rst_ram_we", 32'(bus.ram_we), 32'(0));
        check("rst_done", 32'(instr_done), 32'(0));

        // ADD timing: write strobe in cycle 3, then reset lands mid-EXEC
        reset = 1'b0;
        #1;
        check("fetch_rom_rd", 32'(bus.rom_rd), 32'(1));
        check("fetch_rom_addr", 32'(bus.rom_addr), 32'(0));
        @(posedge clock);
        @(posedge clock);
        #1;
        check("add_we", 32'(bus.ram_we), 32'(1));
        check("add_addr", 32'(bus.ram_addr), 32'(3));
        check("add_wdata", 32'(bus.ram_wdata), 32'h10);
        check("add_done", 32'(instr_done), 32'(1));
        reset = 1'b1;
        #1;
        check("rst_mid_exec_we", 32'(bus.ram_we), 32'(0));
        check("rst_mid_exec_done", 32'(instr_done), 32'(0));
        @(posedge clock);
        #1;
        check("rst_mid_exec_pc", 32'(pc), 32'(0));
        check("rst_mid_exec_carry", 32'(carry), 32'(0));
        check("rst_mid_exec_op", 32'(op), 32'(0));
        reset = 1'b0;
        #1;
        check("rst_mid_exec_fetch", 32'(bus.rom_rd), 32'(1));
        reset = 1'b1;

        // Main program
        for (int i = 0; i < 16; i++) rom[i] = enc(NOP, 8'h00, 8'h00, 4'h0);
        rom[0]  = enc(JZ,   8'h06, 8'h00, 4'h0);
        rom[1]  = enc(ADD,  8'hF0, 8'h20, 4'h3);
        rom[2]  = enc(SUB,  8'h05, 8'h05, 4'h1);
        rom[3]  = enc(JZ,   8'h09, 8'h00, 4'h0);
        rom[9]  = enc(LD,   8'h00, 8'h00, 4'h2);
        rom[10] = enc(AND,  8'h0F, 8'hF0, 4'h4);
        rom[11] = enc(SUB,  8'h03, 8'h05, 4'h5);
        rom[12] = enc(JMP,  8'h0E, 8'h00, 4'h0);
        rom[14] = enc(SUB,  8'h07, 8'h07, 4'h6);
        rom[15] = enc(NOP,  8'h00, 8'h00, 4'h0);
        rom[6]  = enc(HALT, 8'h00, 8'h00, 4'h0);

        ret_q.push_back(mk_ret(4'd1,  8'h00, 1'b0, 1'b0, 1'b0));  // JZ not taken
        ret_q.push_back(mk_ret(4'd2,  8'h00, 1'b0, 1'b1, 1'b0));  // ADD F0+20
        ret_q.push_back(mk_ret(4'd3,  8'h00, 1'b1, 1'b0, 1'b0));  // SUB 5-5
        ret_q.push_back(mk_ret(4'd9,  8'h00, 1'b1, 1'b0, 1'b0));  // JZ taken
        ret_q.push_back(mk_ret(4'd10, 8'hA5, 1'b0, 1'b0, 1'b0));  // LD ram[2]
        ret_q.push_back(mk_ret(4'd11, 8'hA5, 1'b1, 1'b0, 1'b0));  // AND
        ret_q.push_back(mk_ret(4'd12, 8'hA5, 1'b0, 1'b1, 1'b0));  // SUB 3-5
        ret_q.push_back(mk_ret(4'd14, 8'hA5, 1'b0, 1'b1, 1'b0));  // JMP
        ret_q.push_back(mk_ret(4'd15, 8'hA5, 1'b1, 1'b0, 1'b0));  // SUB 7-7
        ret_q.push_back(mk_ret(4'd0,  8'hA5, 1'b1, 1'b0, 1'b0));  // NOP, pc wraps
        ret_q.push_back(mk_ret(4'd6,  8'hA5, 1'b1, 1'b0, 1'b0));  // JZ taken
        ret_q.push_back(mk_ret(4'd6,  8'hA5, 1'b1, 1'b0, 1'b1));  // HALT
        wr_q.push_back(mk_wr(4'h3, 8'h10));
        wr_q.push_back(mk_wr(4'h1, 8'h00));
        wr_q.push_back(mk_wr(4'h4, 8'h00));
        wr_q.push_back(mk_wr(4'h5, 8'hFE));
        wr_q.push_back(mk_wr(4'h6, 8'h00));

        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        // Now in DECODE: stall for five cycles
        ena = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            check("stall_pc", 32'(pc), 32'(0));
            check("stall_op", 32'(op), 32'(0));
            check("stall_rom_rd", 32'(bus.rom_rd), 32'(0));
            check("stall_done", 32'(instr_done), 32'(0));
        end
        ena = 1'b1;
        @(posedge clock);
        #1;
        check("resume_op", 32'(op), 32'(JZ));
        check("resume_x", 32'(x), 32'h06);

        cyc = 0;
        while (!halted && cyc < 300) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("halt_reached", 32'(halted), 32'(1));
        @(posedge clock);
        #2;
        check("retire_q_empty", 32'(ret_q.size()), 32'(0));
        check("write_q_empty", 32'(wr_q.size()), 32'(0));

        repeat (20) begin
            @(posedge clock);
            #1;
            check("halt_pc", 32'(pc), 32'(6));
            check("halt_flag", 32'(halted), 32'(1));
            check("halt_rom_rd", 32'(bus.rom_rd), 32'(0));
            check("halt_done", 32'(instr_done), 32'(0));
        end

        reset = 1'b1;
        @(posedge clock);
        #1;
        check("post_halt_rst_pc", 32'(pc), 32'(0));
        check("post_halt_rst_halted", 32'(halted), 32'(0));
        check("post_halt_rst_acc", 32'(acc), 32'(0));
        check("post_halt_rst_zero", 32'(zero), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
